// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: playfield defaults, line-clear FSM states,
// base scoring awards and the playfield cell-index helper.
package tetris_pkg;

    localparam int unsigned PLAY_WIDTH_DEF  = 10;
    localparam int unsigned PLAY_HEIGHT_DEF = 15;
    localparam int unsigned COLOR_W_DEF     = 3;

    typedef enum logic [2:0] {
        LC_IDLE,
        LC_SCAN,
        LC_SHIFT,
        LC_SCORE,
        LC_DONE
    } lc_state_t;

    // Base awards for 1, 2, 3 and 4-or-more lines in one lock.
    localparam int unsigned BASE_W = 11;
    localparam logic [BASE_W-1:0] BASE_1 = 11'd40;
    localparam logic [BASE_W-1:0] BASE_2 = 11'd100;
    localparam logic [BASE_W-1:0] BASE_3 = 11'd300;
    localparam logic [BASE_W-1:0] BASE_4 = 11'd1200;

    // Flat cell index: row 0 is the top row.
    function automatic int unsigned idx(input int unsigned row,
                                        input int unsigned col,
                                        input int unsigned width = PLAY_WIDTH_DEF);
        return row * width + col;
    endfunction

endpackage

// File: rtl/line_score_calc.sv
// Combinational score update: level-weighted award for k cleared lines,
// added to the running totals with saturation at all-ones.
module line_score_calc
    import tetris_pkg::*;
#(
    parameter int unsigned K_W     = 4,
    parameter int unsigned LEVEL_W = 4,
    parameter int unsigned SCORE_W = 20,
    parameter int unsigned LINES_W = 12
) (
    input  logic [K_W-1:0]     k_i,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic [LINES_W-1:0] lines_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [LINES_W-1:0] lines_o
);

    localparam int unsigned AWARD_W = BASE_W + LEVEL_W + 1;
    localparam int unsigned SSUM_W  = ((SCORE_W > AWARD_W) ? SCORE_W : AWARD_W) + 1;
    localparam int unsigned LSUM_W  = ((LINES_W > K_W) ? LINES_W : K_W) + 1;

    logic [BASE_W-1:0]  base;
    logic [LEVEL_W:0]   lvl1;
    logic [AWARD_W-1:0] award;
    logic [SSUM_W-1:0]  ssum;
    logic [LSUM_W-1:0]  lsum;

    // Award lookup, weighting, wide sums and saturation.
    always_comb begin
        base = '0;
        case (32'(k_i))
            0:       base = '0;
            1:       base = BASE_1;
            2:       base = BASE_2;
            3:       base = BASE_3;
            default: base = BASE_4;
        endcase
        lvl1  = {1'b0, level_i} + (LEVEL_W + 1)'(1);
        award = AWARD_W'(base) * AWARD_W'(lvl1);
        ssum  = SSUM_W'(score_i) + SSUM_W'(award);
        lsum  = LSUM_W'(lines_i) + LSUM_W'(k_i);
        if (ssum > SSUM_W'({SCORE_W{1'b1}})) begin
            score_o = '1;
        end else begin
            score_o = ssum[SCORE_W-1:0];
        end
        if (lsum > LSUM_W'({LINES_W{1'b1}})) begin
            lines_o = '1;
        end else begin
            lines_o = lsum[LINES_W-1:0];
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Line-clear engine: snapshots the playfield on start, removes full rows
// bottom-to-top one shift per cycle, then scores and publishes the result.
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int unsigned PLAY_WIDTH  = PLAY_WIDTH_DEF,
    parameter int unsigned PLAY_HEIGHT = PLAY_HEIGHT_DEF,
    parameter int unsigned COLOR_W     = COLOR_W_DEF,
    parameter int unsigned LEVEL_W     = 4,
    parameter int unsigned SCORE_W     = 20,
    parameter int unsigned LINES_W     = 12
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] occ_i,
    input  logic [COLOR_W-1:0]                color_i [PLAY_WIDTH*PLAY_HEIGHT],
    input  logic [LEVEL_W-1:0]                level_i,
    input  logic                              score_clr,
    output logic                              busy,
    output logic                              done,
    output logic [PLAY_WIDTH*PLAY_HEIGHT-1:0] occ_o,
    output logic [COLOR_W-1:0]                color_o [PLAY_WIDTH*PLAY_HEIGHT],
    output logic [$clog2(PLAY_HEIGHT+1)-1:0]  lines_cleared,
    output logic [SCORE_W-1:0]                score_total,
    output logic [LINES_W-1:0]                lines_total
);

    localparam int unsigned CELLS = PLAY_WIDTH * PLAY_HEIGHT;
    localparam int unsigned PTR_W = (PLAY_HEIGHT > 1) ? $clog2(PLAY_HEIGHT) : 1;
    localparam int unsigned K_W   = $clog2(PLAY_HEIGHT + 1);

    lc_state_t          state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [LEVEL_W-1:0] lvl_q, lvl_d;

    logic [CELLS-1:0]   snap_occ_q, snap_occ_d;
    logic [COLOR_W-1:0] snap_col_q [CELLS];
    logic [COLOR_W-1:0] snap_col_d [CELLS];

    logic [CELLS-1:0]   occ_q;
    logic [COLOR_W-1:0] col_q [CELLS];
    logic [K_W-1:0]     lc_q;
    logic [SCORE_W-1:0] score_q, score_calc;
    logic [LINES_W-1:0] lines_q, lines_calc;

    logic row_full;

    // Full-row detect on the row under the scan pointer.
    always_comb begin
        row_full = (snap_occ_q[idx(32'(ptr_q), 0, PLAY_WIDTH) +: PLAY_WIDTH] == '1);
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LC_IDLE;
            ptr_q   <= '0;
            k_q     <= '0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
            lvl_q   <= lvl_d;
        end
    end

    // Working playfield snapshot; contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        snap_occ_q <= snap_occ_d;
        snap_col_q <= snap_col_d;
    end

    // Next-state logic: capture, scan, shift-down and sequencing.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        k_d        = k_q;
        lvl_d      = lvl_q;
        snap_occ_d = snap_occ_q;
        snap_col_d = snap_col_q;
        unique case (state_q)
            LC_IDLE: begin
                if (start) begin
                    snap_occ_d = occ_i;
                    snap_col_d = color_i;
                    lvl_d      = level_i;
                    ptr_d      = PTR_W'(PLAY_HEIGHT - 1);
                    k_d        = '0;
                    state_d    = LC_SCAN;
                end
            end
            LC_SCAN: begin
                if (row_full) begin
                    state_d = LC_SHIFT;
                end else if (ptr_q != '0) begin
                    ptr_d = ptr_q - PTR_W'(1);
                end else begin
                    state_d = LC_SCORE;
                end
            end
            LC_SHIFT: begin
                for (int unsigned r = 0; r < PLAY_HEIGHT; r++) begin
                    for (int unsigned c = 0; c < PLAY_WIDTH; c++) begin
                        if (r == 0) begin
                            snap_occ_d[idx(r, c, PLAY_WIDTH)] = 1'b0;
                            snap_col_d[idx(r, c, PLAY_WIDTH)] = '0;
                        end else if (r <= 32'(ptr_q)) begin
                            snap_occ_d[idx(r, c, PLAY_WIDTH)] = snap_occ_q[idx(r - 1, c, PLAY_WIDTH)];
                            snap_col_d[idx(r, c, PLAY_WIDTH)] = snap_col_q[idx(r - 1, c, PLAY_WIDTH)];
                        end
                    end
                end
                k_d     = k_q + K_W'(1);
                state_d = LC_SCAN;
            end
            LC_SCORE: state_d = LC_DONE;
            LC_DONE:  state_d = LC_IDLE;
            default:  state_d = LC_IDLE;
        endcase
    end

    line_score_calc #(
        .K_W     (K_W),
        .LEVEL_W (LEVEL_W),
        .SCORE_W (SCORE_W),
        .LINES_W (LINES_W)
    ) u_score (
        .k_i     (k_q),
        .level_i (lvl_q),
        .score_i (score_q),
        .lines_i (lines_q),
        .score_o (score_calc),
        .lines_o (lines_calc)
    );

    // Published results and running totals; results load on the edge into
    // DONE so they are already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= '0;
            col_q   <= '{default: '0};
            lc_q    <= '0;
            score_q <= '0;
            lines_q <= '0;
        end else begin
            if (state_q == LC_SCORE) begin
                occ_q <= snap_occ_q;
                col_q <= snap_col_q;
                lc_q  <= k_q;
            end
            if (score_clr) begin
                score_q <= '0;
                lines_q <= '0;
            end else if (state_q == LC_SCORE) begin
                score_q <= score_calc;
                lines_q <= lines_calc;
            end
        end
    end

    assign busy          = (state_q != LC_IDLE);
    assign done          = (state_q == LC_DONE);
    assign occ_o         = occ_q;
    assign color_o       = col_q;
    assign lines_cleared = lc_q;
    assign score_total   = score_q;
    assign lines_total   = lines_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: directed playfields, expected
// results queued at issue time and checked by monitors on done.
module tb_line_clear_engine;

    localparam int PW = 10;
    localparam int PH = 15;
    localparam int CW = 3;
    localparam int N  = PW * PH;

    logic           clk = 1'b0;
    logic           reset, start, start8, score_clr, score_clr8;
    logic [N-1:0]   occ_i;
    logic [CW-1:0]  color_i [N];
    logic [3:0]     level_i;

    logic           busy, done, busy8, done8;
    logic [N-1:0]   occ_o, occ_o8;
    logic [CW-1:0]  color_o [N];
    logic [CW-1:0]  color_o8 [N];
    logic [3:0]     lines_cleared, lines_cleared8;
    logic [19:0]    score_total;
    logic [7:0]     score_total8;
    logic [11:0]    lines_total, lines_total8;

    line_clear_engine dut (
        .clk(clk), .reset(reset), .start(start), .occ_i(occ_i), .color_i(color_i),
        .level_i(level_i), .score_clr(score_clr), .busy(busy), .done(done),
        .occ_o(occ_o), .color_o(color_o), .lines_cleared(lines_cleared),
        .score_total(score_total), .lines_total(lines_total)
    );

    line_clear_engine #(.SCORE_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .occ_i(occ_i), .color_i(color_i),
        .level_i(level_i), .score_clr(score_clr8), .busy(busy8), .done(done8),
        .occ_o(occ_o8), .color_o(color_o8), .lines_cleared(lines_cleared8),
        .score_total(score_total8), .lines_total(lines_total8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    occ;
        logic [N*CW-1:0] col;
        logic [3:0]      lc;
        logic [19:0]     score;
        logic [11:0]     lines;
        int              lat;
    } exp_t;

    typedef struct {
        logic [3:0]  lc;
        logic [7:0]  score;
        logic [11:0] lines;
        int          lat;
    } exp8_t;

    exp_t  q[$];
    exp8_t q8[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [N-1:0]    f_occ;
    logic [N*CW-1:0] f_col;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin : mon
        exp_t e;
        logic [N*CW-1:0] cf;
        if (done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = q.pop_front();
                for (int i = 0; i < N; i++) cf[i*CW +: CW] = color_o[i];
                check("occ_o", 512'(occ_o), 512'(e.occ));
                check("color_o", 512'(cf), 512'(e.col));
                check("lines_cleared", 512'(lines_cleared), 512'(e.lc));
                check("score_total", 512'(score_total), 512'(e.score));
                check("lines_total", 512'(lines_total), 512'(e.lines));
                check("latency", 512'(cyc - acc_cyc + 1), 512'(e.lat));
            end
        end
    end

    // Monitor for the narrow-score instance.
    always @(negedge clk) begin : mon8
        exp8_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done8: got done=1 expected no pending op");
            end else begin
                e = q8.pop_front();
                check("lines_cleared8", 512'(lines_cleared8), 512'(e.lc));
                check("score_total8", 512'(score_total8), 512'(e.score));
                check("lines_total8", 512'(lines_total8), 512'(e.lines));
                check("latency8", 512'(cyc - acc_cyc + 1), 512'(e.lat));
            end
        end
    end

    task automatic clear_field();
        f_occ = '0;
        f_col = '0;
    endtask

    task automatic put_row(input int r, input logic [PW-1:0] mask, input logic [CW-1:0] colour);
        for (int c = 0; c < PW; c++) begin
            f_occ[r*PW + c] = mask[c];
            f_col[(r*PW + c)*CW +: CW] = mask[c] ? colour : '0;
        end
    endtask

    task automatic apply_field(input logic [3:0] lvl);
        occ_i = f_occ;
        for (int i = 0; i < N; i++) color_i[i] = f_col[i*CW +: CW];
        level_i = lvl;
    endtask

    // Reference compaction: copy surviving rows downwards into a fresh field.
    task automatic push_exp(input logic [3:0] lc, input logic [19:0] score,
                            input logic [11:0] lines, input int lat);
        exp_t e;
        int w;
        e.occ = '0;
        e.col = '0;
        w = PH - 1;
        for (int r = PH - 1; r >= 0; r--) begin
            if (f_occ[r*PW +: PW] != {PW{1'b1}}) begin
                e.occ[w*PW +: PW] = f_occ[r*PW +: PW];
                e.col[w*PW*CW +: PW*CW] = f_col[r*PW*CW +: PW*CW];
                w--;
            end
        end
        e.lc = lc;
        e.score = score;
        e.lines = lines;
        e.lat = lat;
        q.push_back(e);
    endtask

    task automatic start_op(input logic which8);
        if (which8) start8 = 1'b1;
        else start = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic goto_edge(input int n);
        while ((cyc - acc_cyc) < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input logic which8);
        int n;
        n = 0;
        while ((which8 ? (busy8 || q8.size() != 0) : (busy || q.size() != 0)) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL timeout: got busy after %0d cycles expected idle", n);
            q.delete();
            q8.delete();
        end
    endtask

    task automatic field_bottom_one();
        clear_field();
        put_row(14, 10'h3FF, 3'd1);
        put_row(13, 10'h00F, 3'd2);
        put_row(12, 10'h201, 3'd4);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; start8 = 1'b0;
        score_clr = 1'b0; score_clr8 = 1'b0; level_i = '0; occ_i = '0;
        for (int i = 0; i < N; i++) color_i[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        begin
            logic any_col;
            any_col = 1'b0;
            for (int i = 0; i < N; i++) any_col = any_col | (|color_o[i]);
            check("rst_busy", 512'(busy), 512'(0));
            check("rst_done", 512'(done), 512'(0));
            check("rst_occ_o", 512'(occ_o), 512'(0));
            check("rst_color_o", 512'(any_col), 512'(0));
            check("rst_lines_cleared", 512'(lines_cleared), 512'(0));
            check("rst_score", 512'(score_total), 512'(0));
            check("rst_lines_total", 512'(lines_total), 512'(0));
            check("rst_score8", 512'(score_total8), 512'(0));
        end

        // T1: bottom row full, level 0.
        field_bottom_one();
        apply_field(4'd0);
        push_exp(4'd1, 20'd40, 12'd1, 19);
        start_op(1'b0);
        occ_i = '1;                      // input changes after acceptance are ignored
        wait_idle(1'b0);

        // T2: no full row, level 3.
        clear_field();
        put_row(14, 10'h3FE, 3'd6);
        put_row(13, 10'h155, 3'd7);
        put_row(5, 10'h001, 3'd1);
        apply_field(4'd3);
        push_exp(4'd0, 20'd40, 12'd1, 17);
        start_op(1'b0);
        wait_idle(1'b0);

        // T3: four full rows, partial rows 9/10 in colours 5/3, level 2.
        clear_field();
        for (int r = 11; r < 15; r++) put_row(r, 10'h3FF, 3'(r - 10));
        put_row(10, 10'h0F0, 3'd3);
        put_row(9, 10'h30F, 3'd5);
        apply_field(4'd2);
        push_exp(4'd4, 20'd3640, 12'd5, 25);
        start_op(1'b0);
        wait_idle(1'b0);

        // T4: rows 12 and 14 full, row 13 partial.
        clear_field();
        put_row(14, 10'h3FF, 3'd3);
        put_row(13, 10'h2AA, 3'd2);
        put_row(12, 10'h3FF, 3'd6);
        put_row(11, 10'h001, 3'd7);
        apply_field(4'd0);
        push_exp(4'd2, 20'd3740, 12'd7, 21);
        start_op(1'b0);
        wait_idle(1'b0);

        // T5: no full row; start pulses in cycles 3 and 17 are ignored.
        clear_field();
        put_row(14, 10'h1FF, 3'd5);
        apply_field(4'd1);
        push_exp(4'd0, 20'd3740, 12'd7, 17);
        start_op(1'b0);
        goto_edge(2);  start = 1'b1;
        goto_edge(3);  start = 1'b0;
        goto_edge(16); start = 1'b1;
        goto_edge(17); start = 1'b0;
        check("start_in_done_ignored", 512'(busy), 512'(0));

        // T6: every row full, accepted in the cycle right after DONE.
        clear_field();
        for (int r = 0; r < PH; r++) put_row(r, 10'h3FF, 3'((r % 7) + 1));
        apply_field(4'd0);
        push_exp(4'd15, 20'd4940, 12'd22, 47);
        start_op(1'b0);
        wait_idle(1'b0);

        // Reset in cycle 8 abandons the operation.
        field_bottom_one();
        apply_field(4'd0);
        start_op(1'b0);
        goto_edge(7); reset = 1'b1;
        goto_edge(8); reset = 1'b0;
        check("abort_busy", 512'(busy), 512'(0));
        check("abort_done", 512'(done), 512'(0));
        check("abort_occ_o", 512'(occ_o), 512'(0));
        check("abort_score", 512'(score_total), 512'(0));
        check("abort_lines_total", 512'(lines_total), 512'(0));
        check("abort_lines_cleared", 512'(lines_cleared), 512'(0));

        // T7: normal operation after the abort, level 1.
        field_bottom_one();
        apply_field(4'd1);
        push_exp(4'd1, 20'd80, 12'd1, 19);
        start_op(1'b0);
        wait_idle(1'b0);

        // 8-bit score: saturation, then score_clr landing on the SCORE cycle.
        clear_field();
        for (int r = 11; r < 15; r++) put_row(r, 10'h3FF, 3'd2);
        apply_field(4'd0);
        q8.push_back('{lc: 4'd4, score: 8'd255, lines: 12'd4, lat: 25});
        start_op(1'b1);
        wait_idle(1'b1);
        q8.push_back('{lc: 4'd4, score: 8'd255, lines: 12'd8, lat: 25});
        start_op(1'b1);
        wait_idle(1'b1);
        q8.push_back('{lc: 4'd4, score: 8'd0, lines: 12'd0, lat: 25});
        start_op(1'b1);
        goto_edge(23); score_clr8 = 1'b1;
        goto_edge(24); score_clr8 = 1'b0;
        wait_idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
